// File: rtl/wfg_spi_arbiter_if.sv
// Stream-side bundle between the per-channel waveform sources, the arbiter and wfg_drive_spi.
// The arbiter takes the slave view; the sources and driver together take the master view.
interface wfg_spi_arbiter_if #(
  parameter int NUM_CH          = 4,
  parameter int AXIS_DATA_WIDTH = 32
) ();
  logic [NUM_CH-1:0]                 s_axis_tvalid_i;
  logic [NUM_CH*AXIS_DATA_WIDTH-1:0] s_axis_tdata_i;
  logic [NUM_CH-1:0]                 s_axis_tready_o;
  logic                              m_sync_o;
  logic                              m_axis_tvalid_o;
  logic [AXIS_DATA_WIDTH-1:0]        m_axis_tdata_o;
  logic                              m_axis_tready_i;

  modport slave (
    input  s_axis_tvalid_i, s_axis_tdata_i, m_axis_tready_i,
    output s_axis_tready_o, m_sync_o, m_axis_tvalid_o, m_axis_tdata_o
  );

  modport master (
    output s_axis_tvalid_i, s_axis_tdata_i, m_axis_tready_i,
    input  s_axis_tready_o, m_sync_o, m_axis_tvalid_o, m_axis_tdata_o
  );
endinterface

// File: rtl/wfg_spi_arbiter.sv
// Round-robin arbiter sharing one wfg_drive_spi between NUM_CH stream sources.
// A grant is taken on a pattern sync and held until the driver accepts the word or the grant is aborted.
module wfg_spi_arbiter #(
  parameter int NUM_CH          = 4,
  parameter int AXIS_DATA_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ctrl_en_q_i,
  input  logic [NUM_CH-1:0]    ch_en_q_i,
  input  logic                 wfg_pat_sync_i,
  wfg_spi_arbiter_if.slave     bus,
  output logic [NUM_CH-1:0]    grant_o,
  output logic                 busy_o,
  output logic [7:0]           missed_cnt_o
);
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int W     = AXIS_DATA_WIDTH;

  typedef enum logic {ST_IDLE, ST_GRANT} state_t;

  state_t            state_reg, state_next;
  logic [NUM_CH-1:0] grant_reg, grant_next;
  logic [IDX_W-1:0]  grant_idx_reg, grant_idx_next;
  logic [IDX_W-1:0]  last_grant_reg, last_grant_next;
  logic [W-1:0]      data_reg, data_next;
  logic              sync_reg, sync_next;
  logic [7:0]        missed_reg, missed_next;

  logic [NUM_CH-1:0] eligible;
  logic [W-1:0]      ch_data [NUM_CH];
  logic              sel_found;
  logic [IDX_W-1:0]  sel_idx;
  logic              handshake;
  logic              abort;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_unpack
      assign ch_data[gi] = bus.s_axis_tdata_i[gi*W +: W];
    end
  endgenerate

  assign eligible = bus.s_axis_tvalid_i & ch_en_q_i;

  // First eligible channel after the last served one, wrapping modulo NUM_CH.
  always_comb begin
    int               c;
    logic [IDX_W-1:0] c_idx;
    sel_found = 1'b0;
    sel_idx   = '0;
    c         = 0;
    c_idx     = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      c     = (int'(last_grant_reg) + i) % NUM_CH;
      c_idx = IDX_W'(c);
      if (!sel_found && eligible[c_idx]) begin
        sel_found = 1'b1;
        sel_idx   = c_idx;
      end
    end
  end

  assign handshake = (state_reg == ST_GRANT) && bus.m_axis_tready_i;
  assign abort     = !ctrl_en_q_i || !(|(ch_en_q_i & grant_reg));

  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    grant_idx_next  = grant_idx_reg;
    last_grant_next = last_grant_reg;
    data_next       = data_reg;
    sync_next       = 1'b0;
    missed_next     = missed_reg;
    case (state_reg)
      ST_IDLE: begin
        if (wfg_pat_sync_i && ctrl_en_q_i && sel_found) begin
          state_next     = ST_GRANT;
          grant_next     = NUM_CH'(1) << sel_idx;
          grant_idx_next = sel_idx;
          data_next      = ch_data[sel_idx];
          sync_next      = 1'b1;
        end
      end
      ST_GRANT: begin
        // A completed handshake takes precedence over a same-cycle abort.
        if (handshake) begin
          state_next      = ST_IDLE;
          grant_next      = '0;
          last_grant_next = grant_idx_reg;
        end else if (abort) begin
          state_next = ST_IDLE;
          grant_next = '0;
        end
        if (wfg_pat_sync_i && (missed_reg != 8'hFF)) begin
          missed_next = missed_reg + 8'd1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      grant_reg      <= '0;
      grant_idx_reg  <= '0;
      last_grant_reg <= IDX_W'(NUM_CH - 1);
      data_reg       <= '0;
      sync_reg       <= 1'b0;
      missed_reg     <= 8'd0;
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      grant_idx_reg  <= grant_idx_next;
      last_grant_reg <= last_grant_next;
      data_reg       <= data_next;
      sync_reg       <= sync_next;
      missed_reg     <= missed_next;
    end
  end

  assign bus.s_axis_tready_o = grant_reg & {NUM_CH{handshake}};
  assign bus.m_sync_o        = sync_reg;
  assign bus.m_axis_tvalid_o = (state_reg == ST_GRANT);
  assign bus.m_axis_tdata_o  = data_reg;
  assign grant_o             = grant_reg;
  assign busy_o              = (state_reg == ST_GRANT);
  assign missed_cnt_o        = missed_reg;
endmodule

// File: tb/tb_wfg_spi_arbiter.sv
// Self-checking bench for wfg_spi_arbiter: vector table for arbitration order plus
// hand-written sequences for missed syncs, aborts and asynchronous reset.
module tb_wfg_spi_arbiter;
  localparam int NUM_CH = 4;
  localparam int W      = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ctrl_en;
  logic [NUM_CH-1:0] ch_en;
  logic              sync;
  logic [NUM_CH-1:0] grant;
  logic              busy;
  logic [7:0]        missed;

  always #5 clk = ~clk;

  wfg_spi_arbiter_if #(.NUM_CH(NUM_CH), .AXIS_DATA_WIDTH(W)) bus ();

  wfg_spi_arbiter #(.NUM_CH(NUM_CH), .AXIS_DATA_WIDTH(W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ctrl_en_q_i    (ctrl_en),
    .ch_en_q_i      (ch_en),
    .wfg_pat_sync_i (sync),
    .bus            (bus),
    .grant_o        (grant),
    .busy_o         (busy),
    .missed_cnt_o   (missed)
  );

  typedef struct {
    logic        ctrl;
    logic [3:0]  en;
    logic [3:0]  valid;
    int          exp_ch;
  } vec_t;

  typedef struct {
    logic [3:0]  grant;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  vec_t vecs[18];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [31:0] word(int k, int n);
    return {8'hA5, 8'(n), 8'hA5, 8'(k + 1)};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Advance to the next falling edge and score any sync pulse the DUT emitted.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (bus.m_sync_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_sync: got m_sync_o=1, expected 0 (grant 0x%0h)", grant);
      end else begin
        e = exp_q.pop_front();
        check("sync_grant", 32'(grant), 32'(e.grant));
        check("sync_tdata", bus.m_axis_tdata_o, e.data);
      end
    end
  endtask

  task automatic set_data(int n);
    for (int k = 0; k < NUM_CH; k++) bus.s_axis_tdata_i[k*W +: W] = word(k, n);
  endtask

  // Drive one sync; exp_ch < 0 means no grant may result.
  task automatic start(logic c, logic [3:0] en, logic [3:0] v, int exp_ch, int n);
    exp_t e;
    ctrl_en             = c;
    ch_en               = en;
    bus.s_axis_tvalid_i = v;
    set_data(n);
    sync = 1'b1;
    if (exp_ch >= 0) begin
      e.grant = 4'(1 << exp_ch);
      e.data  = word(exp_ch, n);
      exp_q.push_back(e);
    end
    tick();
    sync = 1'b0;
    if (exp_ch >= 0) begin
      check("sync_latency_pending", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      check("grant_busy", 32'(busy), 32'd1);
      check("grant_tvalid", 32'(bus.m_axis_tvalid_o), 32'd1);
      // Source data moving during the grant must not reach the driver.
      bus.s_axis_tdata_i = ~bus.s_axis_tdata_i;
      #1;
      check("tdata_held", bus.m_axis_tdata_o, word(exp_ch, n));
    end else begin
      check("no_grant", 32'(grant), 32'd0);
      check("no_grant_busy", 32'(busy), 32'd0);
    end
    $display("txn %0d: ctrl=%0b en=%b valid=%b -> grant=%b (expected ch %0d)", n, c, en, v, grant, exp_ch);
  endtask

  task automatic finish_hs(int exp_ch);
    bus.m_axis_tready_i = 1'b1;
    #1;
    check("s_tready", 32'(bus.s_axis_tready_o), 32'(1 << exp_ch));
    tick();
    bus.m_axis_tready_i = 1'b0;
    check("done_grant", 32'(grant), 32'd0);
    check("done_busy", 32'(busy), 32'd0);
    check("done_tvalid", 32'(bus.m_axis_tvalid_o), 32'd0);
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_grant"}, 32'(grant), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_tvalid"}, 32'(bus.m_axis_tvalid_o), 32'd0);
    check({tag, "_tdata"}, bus.m_axis_tdata_o, 32'd0);
    check({tag, "_sync"}, 32'(bus.m_sync_o), 32'd0);
    check({tag, "_missed"}, 32'(missed), 32'd0);
    check({tag, "_s_tready"}, 32'(bus.s_axis_tready_o), 32'd0);
  endtask

  initial begin
    // Round robin from reset, then single channel, skip and masking cases.
    vecs[0]  = '{1'b1, 4'b1111, 4'b1111, 0};
    vecs[1]  = '{1'b1, 4'b1111, 4'b1111, 1};
    vecs[2]  = '{1'b1, 4'b1111, 4'b1111, 2};
    vecs[3]  = '{1'b1, 4'b1111, 4'b1111, 3};
    vecs[4]  = '{1'b1, 4'b1111, 4'b1111, 0};
    vecs[5]  = '{1'b1, 4'b1111, 4'b1111, 1};
    vecs[6]  = '{1'b1, 4'b1111, 4'b1111, 2};
    vecs[7]  = '{1'b1, 4'b1111, 4'b1111, 3};
    vecs[8]  = '{1'b1, 4'b0001, 4'b0001, 0};
    vecs[9]  = '{1'b1, 4'b1111, 4'b0010, 1};
    vecs[10] = '{1'b1, 4'b1111, 4'b1010, 3};
    vecs[11] = '{1'b1, 4'b1111, 4'b1010, 1};
    vecs[12] = '{1'b1, 4'b1111, 4'b0000, -1};
    vecs[13] = '{1'b1, 4'b0101, 4'b1010, -1};
    vecs[14] = '{1'b1, 4'b0110, 4'b1111, 2};
    vecs[15] = '{1'b1, 4'b1001, 4'b1111, 3};
    vecs[16] = '{1'b1, 4'b1001, 4'b1111, 0};
    vecs[17] = '{1'b0, 4'b1111, 4'b1111, -1};

    rst_n               = 1'b0;
    ctrl_en             = 1'b0;
    ch_en               = '0;
    sync                = 1'b0;
    bus.s_axis_tvalid_i = '0;
    bus.s_axis_tdata_i  = '0;
    bus.m_axis_tready_i = 1'b1;
    tick();
    tick();
    check_reset_outputs("reset");
    bus.m_axis_tready_i = 1'b0;
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 18; i++) begin
      start(vecs[i].ctrl, vecs[i].en, vecs[i].valid, vecs[i].exp_ch, i);
      if (vecs[i].exp_ch >= 0) finish_hs(vecs[i].exp_ch);
      tick();
    end
    check("missed_after_table", 32'(missed), 32'd0);

    // Missed syncs, handshake with coincident sync, immediate re-arbitration, saturation.
    start(1'b1, 4'b1111, 4'b1111, 1, 40);
    repeat (3) begin
      sync = 1'b1;
      tick();
    end
    sync = 1'b0;
    check("missed_3", 32'(missed), 32'd3);
    sync = 1'b1;
    bus.m_axis_tready_i = 1'b1;
    #1;
    check("hs_with_sync_tready", 32'(bus.s_axis_tready_o), 32'b0010);
    tick();
    sync = 1'b0;
    bus.m_axis_tready_i = 1'b0;
    check("missed_hs_sync", 32'(missed), 32'd4);
    check("hs_sync_grant", 32'(grant), 32'd0);
    start(1'b1, 4'b1111, 4'b1111, 2, 41);
    repeat (300) begin
      sync = 1'b1;
      tick();
    end
    sync = 1'b0;
    check("missed_saturate", 32'(missed), 32'd255);
    finish_hs(2);
    tick();

    // Abort by global enable, then by channel enable, then abort coinciding with ready.
    start(1'b1, 4'b1111, 4'b1111, 3, 42);
    ctrl_en = 1'b0;
    tick();
    ctrl_en = 1'b1;
    check("abort_ctrl_grant", 32'(grant), 32'd0);
    check("abort_ctrl_busy", 32'(busy), 32'd0);
    bus.m_axis_tready_i = 1'b1;
    #1;
    check("abort_no_tready", 32'(bus.s_axis_tready_o), 32'd0);
    bus.m_axis_tready_i = 1'b0;
    start(1'b1, 4'b1111, 4'b1111, 3, 43);
    ch_en = 4'b0111;
    tick();
    ch_en = 4'b1111;
    check("abort_ch_grant", 32'(grant), 32'd0);
    start(1'b1, 4'b1111, 4'b1111, 3, 44);
    ctrl_en = 1'b0;
    bus.m_axis_tready_i = 1'b1;
    #1;
    check("abort_hs_tready", 32'(bus.s_axis_tready_o), 32'b1000);
    tick();
    ctrl_en = 1'b1;
    bus.m_axis_tready_i = 1'b0;
    check("abort_hs_grant", 32'(grant), 32'd0);
    start(1'b1, 4'b1111, 4'b1111, 0, 45);
    finish_hs(0);
    tick();

    // Asynchronous reset in the middle of a grant.
    start(1'b1, 4'b1111, 4'b1111, 1, 46);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    tick();
    rst_n = 1'b1;
    tick();
    start(1'b1, 4'b1111, 4'b1111, 0, 47);
    finish_hs(0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
